player_seq_checker: RTL and testbench

- Reader and encoder on the player side of the Genius sequence path.
- Drives a 4-bit step address into the sequence decoder ROM (combinational, one-hot 4-bit colour out) and reads back the expected colour.
- Captures one-hot player button presses, encodes each to a 2-bit colour code, and checks it against the expected colour step by step.
- Reports hit / miss / round-complete to the game controller FSM.

---
 rtl/player_seq_checker.sv | 200 ++++++++++++++++++++
 tb/tb_player_seq_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_seq_checker.sv
// player_seq_checker: player-side step checker for the Genius sequence path.
// Addresses the sequence ROM, synchronises and encodes button presses,
// and reports hit / miss / round-complete to the game controller.
// Optional build macro: PLAYER_TIMEOUT_EN adds a WAIT_PRESS inactivity timeout.
module player_seq_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nivel,
  input  logic [3:0] botoes,
  input  logic [3:0] seq_cor,
  output logic [3:0] address,
  output logic       busy,
  output logic       acerto,
  output logic       erro,
  output logic       rodada_ok,
  output logic       timeout,
  output logic [1:0] cod_botao
);

  localparam int unsigned BTN_W  = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned COD_W  = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] nivel_q, nivel_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              busy_q, busy_d;
  logic              acerto_q, acerto_d;
  logic              erro_q, erro_d;
  logic              rodada_ok_q, rodada_ok_d;
  logic [COD_W-1:0]  cod_q, cod_d;

  logic [SYNC_STAGES-1:0][BTN_W-1:0] sync_q;
  logic [BTN_W-1:0]                  bs;
  logic                              bs_onehot_c;

  // Binary code of a one-hot button vector.
  function automatic logic [COD_W-1:0] encode(input logic [BTN_W-1:0] v);
    logic [COD_W-1:0] c;
    case (v)
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      4'b1000: c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Button synchroniser chain; bs is the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], botoes};
    end
  end

  assign bs          = sync_q[SYNC_STAGES-1];
  assign bs_onehot_c = (bs != '0) && ((bs & (bs - BTN_W'(1))) == '0);

`ifdef PLAYER_TIMEOUT_EN
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             timeout_hit_c;

  assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT_LAST));

  // Inactivity counter and timeout pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // Timeout not built; the parameter is only folded into a sink.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nivel_q     <= '0;
      address_q   <= '0;
      busy_q      <= 1'b0;
      acerto_q    <= 1'b0;
      erro_q      <= 1'b0;
      rodada_ok_q <= 1'b0;
      cod_q       <= '0;
    end else begin
      state_q     <= state_d;
      nivel_q     <= nivel_d;
      address_q   <= address_d;
      busy_q      <= busy_d;
      acerto_q    <= acerto_d;
      erro_q      <= erro_d;
      rodada_ok_q <= rodada_ok_d;
      cod_q       <= cod_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    nivel_d     = nivel_q;
    address_d   = address_q;
    busy_d      = busy_q;
    cod_d       = cod_q;
    acerto_d    = 1'b0;
    erro_d      = 1'b0;
    rodada_ok_d = 1'b0;
`ifdef PLAYER_TIMEOUT_EN
    timeout_d   = 1'b0;
    cnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          nivel_d   = nivel;
          address_d = '0;
          busy_d    = 1'b1;
          state_d   = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (bs_onehot_c) begin
          // A faulty (non one-hot) seq_cor can never equal a one-hot press.
          cod_d = encode(bs);
          if (bs == seq_cor) begin
            acerto_d = 1'b1;
            state_d  = WAIT_RELEASE;
          end else begin
            erro_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (bs != '0) begin
          erro_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef PLAYER_TIMEOUT_EN
        else if (timeout_hit_c) begin
          erro_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      WAIT_RELEASE: begin
        if (bs == '0) begin
          if (address_q == nivel_q) begin
            rodada_ok_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            address_d = address_q + ADDR_W'(1);
            state_d   = WAIT_PRESS;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign address   = address_q;
  assign busy      = busy_q;
  assign acerto    = acerto_q;
  assign erro      = erro_q;
  assign rodada_ok = rodada_ok_q;
  assign cod_botao = cod_q;

endmodule

// File: tb/tb_player_seq_checker.sv
// Self-checking bench for player_seq_checker: directed vectors plus
// randomized rounds checked against a round-level event model.
`timescale 1ns/1ps
module tb_player_seq_checker;

  localparam int unsigned TO_CYCLES = 8;
  localparam int unsigned SYNC      = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] nivel = 4'd0;
  logic [3:0] botoes = 4'd0;
  logic [3:0] seq_cor;
  logic [3:0] address;
  logic       busy, acerto, erro, rodada_ok, timeout;
  logic [1:0] cod_botao;

  logic [3:0] rom [16];

  int checks = 0;
  int errors = 0;

  // One observed or expected output pulse.
  typedef struct packed {
    logic       a;
    logic       e;
    logic       r;
    logic       t;
    logic [1:0] cod;
    logic [3:0] addr;
  } ev_t;

  typedef struct {
    logic [3:0] press;
    ev_t        exp;
    bit         round_end;
    logic       busy_after;
  } vec_t;

  ev_t  evq[$];
  ev_t  expq[$];
  vec_t vt[3];
  int   last_cod;

  player_seq_checker #(
    .TIMEOUT_CYCLES(TO_CYCLES),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .nivel    (nivel),
    .botoes   (botoes),
    .seq_cor  (seq_cor),
    .address  (address),
    .busy     (busy),
    .acerto   (acerto),
    .erro     (erro),
    .rodada_ok(rodada_ok),
    .timeout  (timeout),
    .cod_botao(cod_botao)
  );

  assign seq_cor = rom[address];

  always #5 clk = ~clk;

  // Record every pulse cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && (acerto || erro || rodada_ok || timeout))
      evq.push_back({acerto, erro, rodada_ok, timeout, cod_botao, address});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(input int kind, input int cod, input int addr);
    ev_t v;
    v      = '0;
    v.a    = (kind == 0);
    v.e    = (kind == 1) || (kind == 3);
    v.r    = (kind == 2);
    v.t    = (kind == 3);
    v.cod  = 2'(cod);
    v.addr = 4'(addr);
    return v;
  endfunction

  function automatic int idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) if (v[b]) r = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input string name, input ev_t exp);
    ev_t got;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL %s: no pulse seen, expected a=%b e=%b r=%b t=%b cod=%0d addr=%0d",
               name, exp.a, exp.e, exp.r, exp.t, exp.cod, exp.addr);
    end else begin
      got = evq.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got a=%b e=%b r=%b t=%b cod=%0d addr=%0d expected a=%b e=%b r=%b t=%b cod=%0d addr=%0d",
                 name, got.a, got.e, got.r, got.t, got.cod, got.addr,
                 exp.a, exp.e, exp.r, exp.t, exp.cod, exp.addr);
      end
    end
  endtask

  task automatic expect_quiet(input string name);
    chk(name, 32'(evq.size()), 32'd0);
    evq.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_round(input int n);
    start = 1'b1;
    nivel = 4'(n);
    tick(1);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] p, input int hold, input int gap);
    botoes = p;
    tick(hold);
    botoes = 4'd0;
    tick(gap);
  endtask

  initial begin
    int seen;
    int n;
    bit alive;
    logic [3:0] p;
    logic [3:0] other;

    // ---------------- reset ----------------
    tick(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_address", 32'(address), 32'd0);
    chk("reset_cod", 32'(cod_botao), 32'd0);
    chk("reset_pulses", 32'({acerto, erro, rodada_ok, timeout}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // ---------------- reset mid-round at address 3 ----------------
    for (int a = 0; a < 16; a++) rom[a] = 4'b0001 << (a % 4);
    start_round(5);
    for (int s = 0; s < 3; s++) begin
      press(rom[s], 4, 5);
      expect_ev("midrst_hit", mk(0, s, s));
    end
    chk("midrst_addr_before", 32'(address), 32'd3);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_address", 32'(address), 32'd0);
    chk("midrst_cod", 32'(cod_botao), 32'd0);
    chk("midrst_pulses", 32'({acerto, erro, rodada_ok, timeout}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    expect_quiet("midrst_no_pulse");
    start_round(0);
    chk("post_rst_start_busy", 32'(busy), 32'd1);
    press(rom[0], 4, 5);
    expect_ev("post_rst_hit", mk(0, 0, 0));
    expect_ev("post_rst_round", mk(2, 0, 0));
    chk("post_rst_idle", 32'(busy), 32'd0);

    // ---------------- full correct round, table driven ----------------
    rom[0] = 4'b0001; rom[1] = 4'b1000; rom[2] = 4'b0100;
    vt[0] = '{4'b0001, mk(0, 0, 0), 1'b0, 1'b1};
    vt[1] = '{4'b1000, mk(0, 3, 1), 1'b0, 1'b1};
    vt[2] = '{4'b0100, mk(0, 2, 2), 1'b1, 1'b0};
    start_round(2);
    for (int i = 0; i < 3; i++) begin
      press(vt[i].press, 4, 5);
      expect_ev("full_hit", vt[i].exp);
      if (vt[i].round_end) expect_ev("full_round", mk(2, 2, 2));
      chk("full_busy", 32'(busy), 32'(vt[i].busy_after));
    end
    chk("full_cod", 32'(cod_botao), 32'd2);
    expect_quiet("full_quiet");

    // ---------------- wrong colour ----------------
    rom[0] = 4'b0001; rom[1] = 4'b1000;
    start_round(3);
    press(4'b0001, 4, 5);
    expect_ev("wrong_first_hit", mk(0, 0, 0));
    press(4'b0010, 4, 5);
    expect_ev("wrong_miss", mk(1, 1, 1));
    chk("wrong_busy", 32'(busy), 32'd0);
    chk("wrong_address", 32'(address), 32'd1);
    chk("wrong_cod", 32'(cod_botao), 32'd1);
    tick(5);
    expect_quiet("wrong_no_round");

    // ---------------- multi-press ----------------
    start_round(3);
    press(4'b0101, 4, 5);
    expect_ev("multi_miss", mk(1, 1, 0));
    chk("multi_cod_kept", 32'(cod_botao), 32'd1);
    chk("multi_busy", 32'(busy), 32'd0);

    // ---------------- start while busy ignored ----------------
    start_round(1);
    tick(2);
    start_round(5);
    press(4'b0001, 4, 5);
    expect_ev("busy_start_hit0", mk(0, 0, 0));
    press(4'b1000, 4, 5);
    expect_ev("busy_start_hit1", mk(0, 3, 1));
    expect_ev("busy_start_round", mk(2, 3, 1));
    chk("busy_start_idle", 32'(busy), 32'd0);

    // ---------------- nivel=15, long hold and added button ----------------
    for (int a = 0; a < 16; a++) rom[a] = 4'b0001 << $urandom_range(0, 3);
    start_round(15);
    for (int s = 0; s < 16; s++) begin
      if (s == 5) begin
        press(rom[s], 14, 5);
      end else if (s == 9) begin
        other = {rom[s][2:0], rom[s][3]};
        botoes = rom[s];
        tick(3);
        botoes = rom[s] | other;
        tick(4);
        botoes = 4'd0;
        tick(5);
      end else begin
        press(rom[s], 3, 4);
      end
      expect_ev("b15_hit", mk(0, idx(rom[s]), s));
    end
    expect_ev("b15_round", mk(2, idx(rom[15]), 15));
    chk("b15_address", 32'(address), 32'd15);
    chk("b15_busy", 32'(busy), 32'd0);
    expect_quiet("b15_quiet");
    last_cod = idx(rom[15]);

`ifdef PLAYER_TIMEOUT_EN
    // ---------------- timeout ----------------
    rom[0] = 4'b0010;
    start_round(3);
    seen = -1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (erro && seen < 0) seen = k;
    end
    chk("timeout_latency", 32'(seen), 32'(TO_CYCLES));
    expect_ev("timeout_pulse", mk(3, last_cod, 0));
    chk("timeout_busy", 32'(busy), 32'd0);

    start_round(3);
    tick(5);
    botoes = 4'b0010;
    tick(3);
    chk("late_press_acerto", 32'({acerto, timeout}), 32'b10);
    tick(1);
    botoes = 4'd0;
    tick(5);
    expect_ev("late_press_hit", mk(0, 1, 0));
    tick(15);
    expect_ev("late_press_next_timeout", mk(3, 1, 1));
    expect_quiet("timeout_quiet");
    last_cod = 1;
`else
    // ---------------- no timeout: wait indefinitely ----------------
    rom[0] = 4'b0010;
    start_round(0);
    tick(40);
    expect_quiet("no_timeout_quiet");
    chk("no_timeout_busy", 32'(busy), 32'd1);
    press(4'b0010, 4, 5);
    expect_ev("no_timeout_hit", mk(0, 1, 0));
    expect_ev("no_timeout_round", mk(2, 1, 0));
    last_cod = 1;
`endif

    // ---------------- randomized rounds vs event model ----------------
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < 16; a++) begin
        rom[a] = 4'b0001 << $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0)
          rom[a] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0110;
      end
      n = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) n = 15;
      expq.delete();
      start_round(n);
      alive = 1'b1;
      for (int s = 0; s <= n && alive; s++) begin
        seen = $urandom_range(0, 99);
        if (seen < 80) begin
          p = ($countones(rom[s]) == 1) ? rom[s] : (4'b0001 << $urandom_range(0, 3));
        end else if (seen < 90) begin
          p = 4'b0001 << $urandom_range(0, 3);
        end else begin
          p = 4'($urandom_range(0, 15));
          if ($countones(p) < 2) p = p | 4'b1001;
        end
        press(p, $urandom_range(3, 5), $urandom_range(3, 4));
        if ($countones(p) == 1) begin
          last_cod = idx(p);
          if (p == rom[s]) begin
            expq.push_back(mk(0, last_cod, s));
          end else begin
            expq.push_back(mk(1, last_cod, s));
            alive = 1'b0;
          end
        end else begin
          expq.push_back(mk(1, last_cod, s));
          alive = 1'b0;
        end
      end
      if (alive) expq.push_back(mk(2, last_cod, n));
      tick(4);
      while (expq.size() > 0) expect_ev("rand_event", expq.pop_front());
      expect_quiet("rand_quiet");
      chk("rand_busy_end", 32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
